pc_gen: RTL and testbench
=========================

# pc_gen

Parametrised program-counter generator for the fetch stage, replacing the fixed 32-bit PC register. It produces the fetch address and a fetch-valid qualifier for the instruction cache, and advances only on an accepted valid/ready handshake. It takes redirects from EX (misprediction correction), ID (decoded jump) and the branch predictor, and inserts a configurable number of bubble cycles after each redirect. An epoch tag lets downstream stages squash fetches issued under a stale path.

## Interface
Parameters:
- XLEN, 32, address width in bits
- RESET_PC, 0, first fetch address after reset; must be aligned to INST_BYTES
- INST_BYTES, 4, instruction size in bytes; power of two, at least 2
- REDIRECT_BUBBLES, 1, cycles fetch_valid_o stays low after a redirect; legal range 0..7
- EPOCH_W, 2, width of the epoch tag

Ports:
- Reset is rst, synchronous, active-high; the clock is clk.
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- stall_i  in  1  pipeline-control stall for the fetch stage
- fetch_ready_i  in  1  I-cache accepts pc_o this cycle
- ex_redir_i  in  1  EX redirect request
- ex_target_i  in  XLEN  EX redirect target
- id_redir_i  in  1  ID redirect request
- id_target_i  in  XLEN  ID redirect target
- pdt_taken_i  in  1  predictor says the current pc_o is a taken branch
- pdt_target_i  in  XLEN  predicted target for the current pc_o
- pc_o  out  XLEN  fetch address
- fetch_valid_o  out  1  pc_o is a valid fetch request
- epoch_o  out  EPOCH_W  path epoch, incremented on every redirect

## Operation
- States are OFF, RUN and BUBBLE.
- Reset: state is OFF; pc_o is RESET_PC, fetch_valid_o is 0, epoch_o is 0 and the bubble counter is 0.
  - All request inputs are ignored while rst is high.
- OFF to RUN: on the first edge with rst low. fetch_valid_o becomes 1 with pc_o still at RESET_PC.
- accept = fetch_valid_o & fetch_ready_i & !stall_i.
- Next-PC priority, highest first:
  1. EX redirect
  2. ID redirect
  3. accept & pdt_taken_i, giving pdt_target_i
  4. accept, giving pc_o + INST_BYTES
  5. hold
- A redirect (EX or ID) takes effect in RUN or BUBBLE regardless of stall_i or fetch_ready_i. It cancels any outstanding unaccepted request.
  - pc_o loads the target.
  - epoch_o increments by one, wrapping modulo 2^EPOCH_W.
  - If REDIRECT_BUBBLES > 0: state goes to BUBBLE, the counter loads REDIRECT_BUBBLES and fetch_valid_o is 0.
  - If REDIRECT_BUBBLES is 0: the block stays in RUN with fetch_valid_o at 1.
- BUBBLE:
  - The counter decrements every cycle, independent of stall_i.
  - When it reaches 0, state returns to RUN and fetch_valid_o returns to 1.
  - A new redirect during BUBBLE reloads the counter and increments the epoch again.
  - Predictor input is ignored.
- Alignment: every loaded target (EX, ID or predictor) has its low log2(INST_BYTES) bits forced to 0.
- Arithmetic: pc_o + INST_BYTES wraps modulo 2^XLEN.
- Handshake: while fetch_valid_o is 1 and no accept and no redirect occur, pc_o is stable.
- Simultaneous events:
  - EX and ID in the same cycle: EX wins, and the epoch increments once.
  - A redirect together with an accept: the redirect wins.
  - rst overrides everything.

## Timing
- All state is registered, with no combinational input-to-output path.
- Reset release: fetch_valid_o goes high 1 cycle after the first edge with rst low.
- Accept at edge N: the new pc_o is visible after edge N.
- Redirect at edge N, with B = REDIRECT_BUBBLES:
  - pc_o holds the target and the epoch is incremented after edge N.
  - fetch_valid_o is 0 for cycles N+1..N+B and 1 from cycle N+B+1.
- Redirect latency from request to target on pc_o: 1 cycle.
- rst asserted mid-BUBBLE or mid-request: the state returns to the full reset values on the next edge.

## Structure
- pc_gen_pkg holds:
  - the state enum (OFF, RUN, BUBBLE)
  - default XLEN, INST_BYTES and RESET_PC constants
  - the ChipEnable/ChipDisable equivalents for fetch_valid_o
- Sub-module pc_redirect_arb: combinational priority select of the next-PC source and alignment masking. It outputs next_pc and redirect_taken.
- The top module holds the state register, bubble counter, pc register and epoch counter.

## Test plan
- Reset and advance: rst high for 3 cycles, then low, with ready=1 and RESET_PC=0x100. Required: fetch_valid_o rises 1 cycle after the first edge with rst low; then pc_o is 0x100, 0x104, 0x108 on successive cycles and epoch_o is 0.
- Stall and not-ready hold: at pc_o=0x108, hold stall_i=1 for 2 cycles, then ready=0 for 2 cycles. Required: pc_o stays 0x108; it moves to 0x10C only after both are released.
- Redirect with bubbles: B=2, ex_redir_i with target 0x2003. Required: pc_o is 0x2000, epoch_o is 1, fetch_valid_o is low for exactly 2 cycles, then fetch resumes at 0x2000, 0x2004.
- Priority: EX=0x3000, ID=0x4000 and pdt_taken=1 in the same cycle. Required: pc_o is 0x3000 and epoch increments by exactly 1.
  - Then pdt_taken with target 0x5000 on an accepted cycle. Required: pc_o is 0x5000 with no bubble and no epoch change.
- Wrap-around: pc_o=0xFFFFFFFC with an accept. Required: pc_o is 0x0.
  - With EPOCH_W=2, 4 back-to-back redirects. Required: epoch_o ends at 0.
- Reset mid-bubble: B=3, redirect, then rst asserted in the 2nd bubble cycle. Required: pc_o is RESET_PC, epoch_o is 0 and fetch_valid_o is 0 on the next edge.

Source files
------------

// File: rtl/pc_gen_pkg.sv
// Shared types and defaults for the fetch-stage program-counter generator.
// Imported by pc_gen and its next-PC arbiter.
package pc_gen_pkg;

    localparam int          DEF_XLEN       = 32;
    localparam int          DEF_INST_BYTES = 4;
    localparam logic [31:0] DEF_RESET_PC   = 32'h0000_0000;

    // The bubble count has a legal range of 0..7, so three bits are enough.
    localparam int BUBBLE_CNT_W = 3;

    localparam logic CHIP_ENABLE  = 1'b1;
    localparam logic CHIP_DISABLE = 1'b0;

    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_RUN    = 2'd1,
        ST_BUBBLE = 2'd2
    } pc_state_e;

endpackage

// File: rtl/pc_redirect_arb.sv
// Combinational next-PC select: EX redirect > ID redirect > predicted taken > sequential > hold.
// Every loaded target has its sub-instruction offset bits cleared.
module pc_redirect_arb
    import pc_gen_pkg::*;
#(
    parameter int XLEN       = DEF_XLEN,
    parameter int INST_BYTES = DEF_INST_BYTES
) (
    input  logic            redir_en_i,
    input  logic            ex_redir_i,
    input  logic [XLEN-1:0] ex_target_i,
    input  logic            id_redir_i,
    input  logic [XLEN-1:0] id_target_i,
    input  logic            pdt_taken_i,
    input  logic [XLEN-1:0] pdt_target_i,
    input  logic            accept_i,
    input  logic [XLEN-1:0] pc_i,
    output logic [XLEN-1:0] next_pc_o,
    output logic            redirect_taken_o
);

    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(INST_BYTES - 1);
    localparam logic [XLEN-1:0] PC_STEP    = XLEN'(INST_BYTES);

    always_comb begin
        next_pc_o        = pc_i;
        redirect_taken_o = 1'b0;
        if (redir_en_i && ex_redir_i) begin
            next_pc_o        = ex_target_i & ALIGN_MASK;
            redirect_taken_o = 1'b1;
        end else if (redir_en_i && id_redir_i) begin
            next_pc_o        = id_target_i & ALIGN_MASK;
            redirect_taken_o = 1'b1;
        end else if (accept_i && pdt_taken_i) begin
            next_pc_o = pdt_target_i & ALIGN_MASK;
        end else if (accept_i) begin
            // Sequential step wraps naturally at the XLEN boundary.
            next_pc_o = pc_i + PC_STEP;
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage program counter: advances on accepted fetches, takes EX/ID/predictor
// redirects, inserts post-redirect bubbles and tags every path with an epoch.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int              XLEN             = DEF_XLEN,
    parameter logic [XLEN-1:0] RESET_PC         = XLEN'(DEF_RESET_PC),
    parameter int              INST_BYTES       = DEF_INST_BYTES,
    parameter int              REDIRECT_BUBBLES = 1,
    parameter int              EPOCH_W          = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall_i,
    input  logic               fetch_ready_i,
    input  logic               ex_redir_i,
    input  logic [XLEN-1:0]    ex_target_i,
    input  logic               id_redir_i,
    input  logic [XLEN-1:0]    id_target_i,
    input  logic               pdt_taken_i,
    input  logic [XLEN-1:0]    pdt_target_i,
    output logic [XLEN-1:0]    pc_o,
    output logic               fetch_valid_o,
    output logic [EPOCH_W-1:0] epoch_o
);

    // Handshake: a fetch of pc_o completes on an edge where fetch_valid_o and
    // fetch_ready_i are high and stall_i is low; pc_o is held until that or a redirect.

    localparam logic [BUBBLE_CNT_W-1:0] BUBBLE_LOAD = BUBBLE_CNT_W'(REDIRECT_BUBBLES);

    pc_state_e              state_q, state_d;
    logic [XLEN-1:0]        pc_q, pc_d;
    logic                   valid_q, valid_d;
    logic [EPOCH_W-1:0]     epoch_q, epoch_d;
    logic [BUBBLE_CNT_W-1:0] cnt_q, cnt_d;

    logic            accept;
    logic            redir_en;
    logic [XLEN-1:0] next_pc;
    logic            redirect_taken;

    assign accept   = valid_q & fetch_ready_i & ~stall_i;
    assign redir_en = (state_q == ST_RUN) || (state_q == ST_BUBBLE);

    pc_redirect_arb #(
        .XLEN       (XLEN),
        .INST_BYTES (INST_BYTES)
    ) u_arb (
        .redir_en_i       (redir_en),
        .ex_redir_i       (ex_redir_i),
        .ex_target_i      (ex_target_i),
        .id_redir_i       (id_redir_i),
        .id_target_i      (id_target_i),
        .pdt_taken_i      (pdt_taken_i),
        .pdt_target_i     (pdt_target_i),
        .accept_i         (accept),
        .pc_i             (pc_q),
        .next_pc_o        (next_pc),
        .redirect_taken_o (redirect_taken)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        epoch_d = epoch_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_OFF: begin
                state_d = ST_RUN;
                valid_d = CHIP_ENABLE;
            end
            ST_RUN, ST_BUBBLE: begin
                if (redirect_taken) begin
                    pc_d    = next_pc;
                    epoch_d = epoch_q + EPOCH_W'(1);
                    if (REDIRECT_BUBBLES == 0) begin
                        state_d = ST_RUN;
                        valid_d = CHIP_ENABLE;
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_BUBBLE;
                        valid_d = CHIP_DISABLE;
                        cnt_d   = BUBBLE_LOAD;
                    end
                end else if (state_q == ST_BUBBLE) begin
                    // The last bubble cycle ends on the edge that takes the count to zero.
                    if (cnt_q <= BUBBLE_CNT_W'(1)) begin
                        state_d = ST_RUN;
                        valid_d = CHIP_ENABLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - BUBBLE_CNT_W'(1);
                    end
                end else begin
                    pc_d = next_pc;
                end
            end
            default: begin
                state_d = ST_OFF;
                valid_d = CHIP_DISABLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_OFF;
            pc_q    <= RESET_PC;
            valid_q <= CHIP_DISABLE;
            epoch_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            epoch_q <= epoch_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pc_o          = pc_q;
    assign fetch_valid_o = valid_q;
    assign epoch_o       = epoch_q;

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: three instances (2, 3 and 0 redirect bubbles) share one stimulus
// stream and are checked against spec constants and a per-instance reference model.
module tb_pc_gen;

    localparam int          NI       = 3;
    localparam logic [31:0] RST_PC   = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_i = 1'b0;
    logic        fetch_ready_i = 1'b0;
    logic        ex_redir_i = 1'b0;
    logic [31:0] ex_target_i = '0;
    logic        id_redir_i = 1'b0;
    logic [31:0] id_target_i = '0;
    logic        pdt_taken_i = 1'b0;
    logic [31:0] pdt_target_i = '0;

    logic [31:0] d_pc    [NI];
    logic        d_valid [NI];
    logic [1:0]  d_epoch [NI];

    int errors = 0;
    int checks = 0;

    // Reference model: fetch pointer, epoch, outstanding bubble cycles, started flag.
    logic [31:0] m_pc    [NI];
    logic        m_valid [NI];
    int          m_epoch [NI];
    int          m_left  [NI];
    bit          m_live  [NI];

    always #5 clk = ~clk;

    function automatic int bub_of(int i);
        return (i == 0) ? 2 : ((i == 1) ? 3 : 0);
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_dut
        pc_gen #(
            .XLEN             (32),
            .RESET_PC         (RST_PC),
            .INST_BYTES       (4),
            .REDIRECT_BUBBLES ((g == 0) ? 2 : ((g == 1) ? 3 : 0)),
            .EPOCH_W          (2)
        ) dut (
            .clk           (clk),
            .rst           (rst),
            .stall_i       (stall_i),
            .fetch_ready_i (fetch_ready_i),
            .ex_redir_i    (ex_redir_i),
            .ex_target_i   (ex_target_i),
            .id_redir_i    (id_redir_i),
            .id_target_i   (id_target_i),
            .pdt_taken_i   (pdt_taken_i),
            .pdt_target_i  (pdt_target_i),
            .pc_o          (d_pc[g]),
            .fetch_valid_o (d_valid[g]),
            .epoch_o       (d_epoch[g])
        );
    end

    function automatic void model_step();
        for (int i = 0; i < NI; i++) begin
            if (rst) begin
                m_pc[i] = RST_PC; m_valid[i] = 1'b0; m_epoch[i] = 0; m_left[i] = 0; m_live[i] = 0;
            end else if (!m_live[i]) begin
                m_live[i] = 1; m_valid[i] = 1'b1;
            end else if (ex_redir_i || id_redir_i) begin
                m_pc[i]    = (ex_redir_i ? ex_target_i : id_target_i) & 32'hFFFF_FFFC;
                m_epoch[i] = (m_epoch[i] + 1) % 4;
                m_left[i]  = bub_of(i);
                m_valid[i] = (bub_of(i) == 0);
            end else if (m_left[i] > 0) begin
                m_left[i]  = m_left[i] - 1;
                m_valid[i] = (m_left[i] == 0);
            end else if (m_valid[i] && fetch_ready_i && !stall_i) begin
                if (pdt_taken_i) m_pc[i] = pdt_target_i & 32'hFFFF_FFFC;
                else             m_pc[i] = m_pc[i] + 32'd4;
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic clear_req();
        ex_redir_i = 1'b0; id_redir_i = 1'b0; pdt_taken_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; fetch_ready_i = 1'b1;
        repeat (3) tick();
        for (int i = 0; i < NI; i++) begin
            checks++;
            if ({d_pc[i], d_valid[i], d_epoch[i]} !== {RST_PC, 1'b0, 2'd0}) begin
                errors++;
                $display("FAIL reset_state[%0d]: pc=%h valid=%b epoch=%0d, want pc=%h valid=0 epoch=0",
                         i, d_pc[i], d_valid[i], d_epoch[i], RST_PC);
            end
        end
        rst = 1'b0;
        tick();
        for (int i = 0; i < NI; i++) begin
            checks++;
            if (d_valid[i] !== 1'b1 || d_pc[i] !== 32'h100) begin
                errors++;
                $display("FAIL reset_release[%0d]: valid=%b pc=%h, want valid=1 pc=00000100", i, d_valid[i], d_pc[i]);
            end
        end
        tick();
        checks++;
        if (d_pc[0] !== 32'h104) begin
            errors++; $display("FAIL advance_1: pc=%h want 00000104", d_pc[0]);
        end
        tick();
        for (int i = 0; i < NI; i++) begin
            checks++;
            if (d_pc[i] !== 32'h108 || d_epoch[i] !== 2'd0) begin
                errors++;
                $display("FAIL advance_2[%0d]: pc=%h epoch=%0d, want pc=00000108 epoch=0", i, d_pc[i], d_epoch[i]);
            end
        end
    endtask

    task automatic test_stall_hold();
        stall_i = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            checks++;
            if (d_pc[0] !== 32'h108 || d_valid[0] !== 1'b1) begin
                errors++; $display("FAIL stall_hold: pc=%h valid=%b want 00000108/1", d_pc[0], d_valid[0]);
            end
        end
        stall_i = 1'b0; fetch_ready_i = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick();
            checks++;
            if (d_pc[0] !== 32'h108) begin
                errors++; $display("FAIL notready_hold: pc=%h want 00000108", d_pc[0]);
            end
        end
        fetch_ready_i = 1'b1;
        tick();
        checks++;
        if (d_pc[0] !== 32'h10C) begin
            errors++; $display("FAIL hold_release: pc=%h want 0000010c", d_pc[0]);
        end
    endtask

    task automatic test_redirect_bubbles();
        logic [1:0] exp_valid [4];
        logic [31:0] exp_pc [4];
        exp_valid[0] = 1'b0; exp_valid[1] = 1'b0; exp_valid[2] = 1'b1; exp_valid[3] = 1'b1;
        exp_pc[0] = 32'h2000; exp_pc[1] = 32'h2000; exp_pc[2] = 32'h2000; exp_pc[3] = 32'h2004;
        ex_redir_i = 1'b1; ex_target_i = 32'h2003; fetch_ready_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            clear_req();
            checks++;
            if (d_pc[0] !== exp_pc[k] || d_valid[0] !== exp_valid[k][0] || d_epoch[0] !== 2'd1) begin
                errors++;
                $display("FAIL redirect_bubble_c%0d: pc=%h valid=%b epoch=%0d, want pc=%h valid=%b epoch=1",
                         k, d_pc[0], d_valid[0], d_epoch[0], exp_pc[k], exp_valid[k][0]);
            end
        end
        for (int i = 1; i < NI; i++) begin
            checks++;
            if (d_pc[i] !== m_pc[i] || d_valid[i] !== m_valid[i]) begin
                errors++;
                $display("FAIL redirect_model[%0d]: pc=%h valid=%b, want pc=%h valid=%b",
                         i, d_pc[i], d_valid[i], m_pc[i], m_valid[i]);
            end
        end
    endtask

    task automatic test_priority();
        int e0;
        fetch_ready_i = 1'b0;
        repeat (4) tick();
        e0 = m_epoch[0];
        ex_redir_i = 1'b1; ex_target_i = 32'h3000;
        id_redir_i = 1'b1; id_target_i = 32'h4000;
        pdt_taken_i = 1'b1; pdt_target_i = 32'h5008; fetch_ready_i = 1'b1;
        tick();
        clear_req(); fetch_ready_i = 1'b0;
        for (int i = 0; i < NI; i++) begin
            checks++;
            if (d_pc[i] !== 32'h3000 || d_epoch[i] !== 2'((e0 + 1) % 4)) begin
                errors++;
                $display("FAIL priority_ex[%0d]: pc=%h epoch=%0d, want pc=00003000 epoch=%0d",
                         i, d_pc[i], d_epoch[i], (e0 + 1) % 4);
            end
        end
        repeat (4) tick();
        pdt_taken_i = 1'b1; pdt_target_i = 32'h5000; fetch_ready_i = 1'b1;
        tick();
        clear_req(); fetch_ready_i = 1'b0;
        for (int i = 0; i < NI; i++) begin
            checks++;
            if (d_pc[i] !== 32'h5000 || d_valid[i] !== 1'b1 || d_epoch[i] !== 2'((e0 + 1) % 4)) begin
                errors++;
                $display("FAIL predict_taken[%0d]: pc=%h valid=%b epoch=%0d, want pc=00005000 valid=1 epoch=%0d",
                         i, d_pc[i], d_valid[i], d_epoch[i], (e0 + 1) % 4);
            end
        end
    endtask

    task automatic test_wrap();
        ex_redir_i = 1'b1; ex_target_i = 32'hFFFF_FFFC;
        tick();
        clear_req();
        repeat (4) tick();
        fetch_ready_i = 1'b1;
        tick();
        fetch_ready_i = 1'b0;
        for (int i = 0; i < NI; i++) begin
            checks++;
            if (d_pc[i] !== 32'h0) begin
                errors++; $display("FAIL pc_wrap[%0d]: pc=%h want 00000000", i, d_pc[i]);
            end
        end
        // Three redirects so far, so one more wraps the epoch to 0.
        id_redir_i = 1'b1; id_target_i = $urandom;
        tick();
        clear_req();
        checks++;
        if (d_epoch[0] !== 2'd0) begin
            errors++; $display("FAIL epoch_wrap: epoch=%0d want 0", d_epoch[0]);
        end
        for (int k = 0; k < 4; k++) begin
            ex_redir_i = $urandom_range(0, 1); id_redir_i = !ex_redir_i;
            ex_target_i = $urandom; id_target_i = $urandom;
            tick();
        end
        clear_req();
        for (int i = 0; i < NI; i++) begin
            checks++;
            if (d_epoch[i] !== 2'd0 || d_pc[i] !== m_pc[i]) begin
                errors++;
                $display("FAIL epoch_4_redirects[%0d]: epoch=%0d pc=%h, want epoch=0 pc=%h",
                         i, d_epoch[i], d_pc[i], m_pc[i]);
            end
        end
    endtask

    task automatic test_reset_mid_bubble();
        fetch_ready_i = 1'b0;
        repeat (4) tick();
        ex_redir_i = 1'b1; ex_target_i = 32'h6000;
        tick();
        clear_req();
        tick();
        checks++;
        if (d_valid[1] !== 1'b0 || d_pc[1] !== 32'h6000) begin
            errors++; $display("FAIL mid_bubble: valid=%b pc=%h want 0/00006000", d_valid[1], d_pc[1]);
        end
        rst = 1'b1;
        ex_redir_i = 1'b1; ex_target_i = 32'h7000;
        tick();
        clear_req();
        for (int i = 0; i < NI; i++) begin
            checks++;
            if ({d_pc[i], d_valid[i], d_epoch[i]} !== {RST_PC, 1'b0, 2'd0}) begin
                errors++;
                $display("FAIL reset_mid_bubble[%0d]: pc=%h valid=%b epoch=%0d, want pc=%h valid=0 epoch=0",
                         i, d_pc[i], d_valid[i], d_epoch[i], RST_PC);
            end
        end
        rst = 1'b0;
        tick();
        checks++;
        if (d_valid[1] !== 1'b1 || d_pc[1] !== RST_PC) begin
            errors++; $display("FAIL restart_after_reset: valid=%b pc=%h want 1/%h", d_valid[1], d_pc[1], RST_PC);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            rst           = ($urandom_range(0, 79) == 0);
            stall_i       = ($urandom_range(0, 3) == 0);
            fetch_ready_i = ($urandom_range(0, 3) != 0);
            ex_redir_i    = ($urandom_range(0, 15) == 0);
            id_redir_i    = ($urandom_range(0, 11) == 0);
            pdt_taken_i   = ($urandom_range(0, 4) == 0);
            ex_target_i   = $urandom;
            id_target_i   = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF4 : $urandom;
            pdt_target_i  = $urandom;
            tick();
            for (int i = 0; i < NI; i++) begin
                checks++;
                if (d_pc[i] !== m_pc[i] || d_valid[i] !== m_valid[i] || d_epoch[i] !== 2'(m_epoch[i])) begin
                    errors++;
                    $display("FAIL random_c%0d[%0d]: pc=%h valid=%b epoch=%0d, want pc=%h valid=%b epoch=%0d",
                             n, i, d_pc[i], d_valid[i], d_epoch[i], m_pc[i], m_valid[i], m_epoch[i]);
                end
            end
        end
        rst = 1'b0;
        clear_req();
    endtask

    initial begin
        for (int i = 0; i < NI; i++) begin
            m_pc[i] = RST_PC; m_valid[i] = 1'b0; m_epoch[i] = 0; m_left[i] = 0; m_live[i] = 0;
        end
        test_reset();
        test_stall_hold();
        test_redirect_bubbles();
        test_priority();
        test_wrap();
        test_reset_mid_bubble();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
